coffee_vend_controller: RTL and testbench

//  Sequencing controller for the single-product coffee vending datapath.
//  - Accumulates coin credit and accepts or ignores buy requests against PRICE.
//  - Drives the cup/brew/dispense sequence, then returns change one coin per cycle.
//  - Sits between the coin/button front-end and the dispenser actuators; it replaces ad-hoc coin/buy handling.

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_if.sv | 32 +++
 rtl/brew_timer.sv | 35 +++
 rtl/coffee_vend_controller.sv | 151 +++++++++++++++
 tb/tb_coffee_vend_controller.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the coffee vending controller.
// Holds the FSM state encoding and the default product/credit/brew
// constants that the top, the interface and the testbench agree on.
package vend_pkg;

  localparam int DEF_PRICE       = 3;
  localparam int DEF_MAX_CREDIT  = 7;
  localparam int DEF_BREW_CYCLES = 4;
  localparam int DEF_CREDIT_W    = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CUP    = 3'd1,
    BREW   = 3'd2,
    DONE   = 3'd3,
    CHANGE = 3'd4
  } state_t;

endpackage

// File: rtl/vend_if.sv
// Front-end <-> controller signal bundle for the coffee vending machine.
//   coin, buy, cancel         : front-end requests, sampled once per cycle
//   cup_drop, brew_en, coffee : dispenser actuator controls
//   coin_return, coin_reject  : coin mechanism pulses
//   busy, credit              : status back to the front-end
// master = coin/button front-end, slave = controller.
interface vend_if #(
  parameter int CREDIT_W = vend_pkg::DEF_CREDIT_W
);

  logic                coin;
  logic                buy;
  logic                cancel;
  logic                cup_drop;
  logic                brew_en;
  logic                coffee;
  logic                coin_return;
  logic                coin_reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin, buy, cancel,
    input  cup_drop, brew_en, coffee, coin_return, coin_reject, busy, credit
  );

  modport slave (
    input  coin, buy, cancel,
    output cup_drop, brew_en, coffee, coin_return, coin_reject, busy, credit
  );

endinterface

// File: rtl/brew_timer.sv
// Loadable down-counter that times the brew phase.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one (never below zero)
//   zero       : count has reached zero
module brew_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load, decrement with floor at zero, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/coffee_vend_controller.sv
// Sequencing controller for the single-product coffee vending machine.
// Accumulates coin credit, accepts a buy when credit covers PRICE, runs the
// cup -> brew -> deliver sequence and then returns change one coin per cycle.
//   clk   : rising-edge clock
//   rst_n : async active-low reset (clears state, credit and all outputs)
//   bus   : vend_if slave (requests in; actuator pulses, busy, credit out)
// All outputs are registered and reflect the state entered at the last edge.
module coffee_vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE       = DEF_PRICE,
  parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int BREW_CYCLES = DEF_BREW_CYCLES,
  parameter int CREDIT_W    = DEF_CREDIT_W
) (
  input  logic  clk,
  input  logic  rst_n,
  vend_if.slave bus
);

  localparam int TW = $clog2(BREW_CYCLES + 1);

  localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] PRICE_C     = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_C       = CREDIT_W'(MAX_CREDIT);
  // Loaded while in CUP so the last BREW cycle sees zero.
  localparam logic [TW-1:0]       BREW_LOAD   = TW'(BREW_CYCLES - 1);

  state_t              state_r, state_next_s;
  logic [CREDIT_W-1:0] credit_r, credit_next_s, base_s;
  logic                reject_s;
  logic                timer_load_s, timer_en_s, timer_zero_s;
  logic                cup_drop_r, brew_en_r, coffee_r;
  logic                coin_return_r, coin_reject_r, busy_r;

  brew_timer #(.W(TW)) u_brew_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (BREW_LOAD),
    .en       (timer_en_s),
    .zero     (timer_zero_s)
  );

  // Next-state, next-credit and coin-reject decode.
  always_comb begin
    state_next_s  = state_r;
    credit_next_s = credit_r;
    base_s        = credit_r;
    reject_s      = 1'b0;
    timer_load_s  = 1'b0;
    timer_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // buy is judged on credit before this cycle's coin; cancel wins.
        if (bus.cancel && (credit_r != CREDIT_ZERO)) begin
          state_next_s = CHANGE;
        end else if (bus.buy && (credit_r >= PRICE_C)) begin
          state_next_s = CUP;
          base_s       = credit_r - PRICE_C;
        end else begin
          state_next_s = IDLE;
        end
        // A coin lands on the post-buy credit, saturating at MAX_CREDIT.
        if (bus.coin) begin
          if (base_s < MAX_C) begin
            credit_next_s = base_s + CREDIT_ONE;
          end else begin
            credit_next_s = base_s;
            reject_s      = 1'b1;
          end
        end else begin
          credit_next_s = base_s;
        end
      end
      CUP: begin
        reject_s     = bus.coin;
        timer_load_s = 1'b1;
        state_next_s = BREW;
      end
      BREW: begin
        reject_s = bus.coin;
        if (timer_zero_s) begin
          state_next_s = DONE;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      DONE: begin
        reject_s = bus.coin;
        if (credit_r != CREDIT_ZERO) begin
          state_next_s = CHANGE;
        end else begin
          state_next_s = IDLE;
        end
      end
      CHANGE: begin
        reject_s = bus.coin;
        // Each cycle here returns one coin; leave as the last one goes.
        if (credit_r != CREDIT_ZERO) begin
          credit_next_s = credit_r - CREDIT_ONE;
        end else begin
          credit_next_s = credit_r;
        end
        if (credit_r <= CREDIT_ONE) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CHANGE;
        end
      end
      default: begin
        reject_s      = 1'b0;
        state_next_s  = IDLE;
        credit_next_s = CREDIT_ZERO;
      end
    endcase
  end

  // State, credit and output registers; outputs decode the entered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      credit_r      <= CREDIT_ZERO;
      cup_drop_r    <= 1'b0;
      brew_en_r     <= 1'b0;
      coffee_r      <= 1'b0;
      coin_return_r <= 1'b0;
      coin_reject_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      credit_r      <= credit_next_s;
      cup_drop_r    <= (state_next_s == CUP);
      brew_en_r     <= (state_next_s == BREW);
      coffee_r      <= (state_next_s == DONE);
      coin_return_r <= (state_next_s == CHANGE);
      coin_reject_r <= reject_s;
      busy_r        <= (state_next_s != IDLE);
    end
  end

  assign bus.cup_drop    = cup_drop_r;
  assign bus.brew_en     = brew_en_r;
  assign bus.coffee      = coffee_r;
  assign bus.coin_return = coin_return_r;
  assign bus.coin_reject = coin_reject_r;
  assign bus.busy        = busy_r;
  assign bus.credit      = credit_r;

endmodule

// File: tb/tb_coffee_vend_controller.sv
// Directed table-driven bench for coffee_vend_controller (PRICE=3,
// MAX_CREDIT=7, BREW_CYCLES=4). Each row gives the inputs for one cycle and
// the outputs expected just after the following rising edge.
// Expected word layout: {cup_drop, brew_en, coffee, coin_return,
//                        coin_reject, busy, credit[2:0]}.
module tb_coffee_vend_controller;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vend_if #(.CREDIT_W(3)) bus ();

  coffee_vend_controller #(
    .PRICE(3), .MAX_CREDIT(7), .BREW_CYCLES(4), .CREDIT_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic       coin;
    logic       buy;
    logic       cancel;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0] idl(input logic [2:0] c); return {6'b000000, c}; endfunction
  function automatic logic [8:0] rej(input logic [2:0] c); return {6'b000010, c}; endfunction
  function automatic logic [8:0] cup(input logic [2:0] c); return {6'b100001, c}; endfunction
  function automatic logic [8:0] brw(input logic [2:0] c); return {6'b010001, c}; endfunction
  function automatic logic [8:0] brj(input logic [2:0] c); return {6'b010011, c}; endfunction
  function automatic logic [8:0] don(input logic [2:0] c); return {6'b001001, c}; endfunction
  function automatic logic [8:0] chg(input logic [2:0] c); return {6'b000101, c}; endfunction

  function automatic logic [8:0] observed();
    return {bus.cup_drop, bus.brew_en, bus.coffee, bus.coin_return,
            bus.coin_reject, bus.busy, bus.credit};
  endfunction

  task automatic add(input string tag, input logic c, input logic b, input logic x,
                     input logic [8:0] e);
    vec_t v;
    v.tag = tag; v.coin = c; v.buy = b; v.cancel = x; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b (cup,brew,coffee,ret,rej,busy,credit[2:0])",
               name, act, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge, check after the rising edge.
  task automatic apply(input string name, input logic c, input logic b, input logic x,
                       input logic [8:0] e);
    bus.coin = c; bus.buy = b; bus.cancel = x;
    @(posedge clk);
    #1;
    check(name, observed(), e);
    @(negedge clk);
  endtask

  initial begin
    // Scenario table.
    add("cancel_zero", 1'b0, 1'b0, 1'b1, idl(3'd0));
    // Exact price.
    for (int i = 1; i <= 3; i++) add("exact_coin", 1'b1, 1'b0, 1'b0, idl(3'(i)));
    add("exact_buy", 1'b0, 1'b1, 1'b0, cup(3'd0));
    for (int i = 0; i < 4; i++) add("exact_brew", 1'b0, 1'b0, 1'b0, brw(3'd0));
    add("exact_done", 1'b0, 1'b0, 1'b0, don(3'd0));
    add("exact_idle", 1'b0, 1'b0, 1'b0, idl(3'd0));
    // Change.
    for (int i = 1; i <= 5; i++) add("chg_coin", 1'b1, 1'b0, 1'b0, idl(3'(i)));
    add("chg_buy", 1'b0, 1'b1, 1'b0, cup(3'd2));
    for (int i = 0; i < 4; i++) add("chg_brew", 1'b0, 1'b0, 1'b0, brw(3'd2));
    add("chg_done", 1'b0, 1'b0, 1'b0, don(3'd2));
    add("chg_ret1", 1'b0, 1'b0, 1'b0, chg(3'd2));
    add("chg_ret2", 1'b0, 1'b0, 1'b0, chg(3'd1));
    add("chg_idle", 1'b0, 1'b0, 1'b0, idl(3'd0));
    // Underpay then cancel.
    for (int i = 1; i <= 2; i++) add("under_coin", 1'b1, 1'b0, 1'b0, idl(3'(i)));
    add("under_buy", 1'b0, 1'b1, 1'b0, idl(3'd2));
    add("under_cancel", 1'b0, 1'b0, 1'b1, chg(3'd2));
    add("under_ret2", 1'b0, 1'b0, 1'b0, chg(3'd1));
    add("under_idle", 1'b0, 1'b0, 1'b0, idl(3'd0));
    // Saturation, then coin/buy/cancel while brewing.
    for (int i = 1; i <= 7; i++) add("sat_coin", 1'b1, 1'b0, 1'b0, idl(3'(i)));
    add("sat_reject", 1'b1, 1'b0, 1'b0, rej(3'd7));
    add("sat_buy", 1'b0, 1'b1, 1'b0, cup(3'd4));
    add("brew_coin", 1'b1, 1'b0, 1'b0, brj(3'd4));
    add("brew_buy", 1'b0, 1'b1, 1'b0, brw(3'd4));
    add("brew_cancel", 1'b0, 1'b0, 1'b1, brw(3'd4));
    add("brew_last", 1'b0, 1'b0, 1'b0, brw(3'd4));
    add("sat_done", 1'b0, 1'b0, 1'b0, don(3'd4));
    for (int i = 4; i >= 1; i--) add("sat_ret", 1'b0, 1'b0, 1'b0, chg(3'(i)));
    add("sat_idle", 1'b0, 1'b0, 1'b0, idl(3'd0));
    // buy + coin together at credit 3.
    for (int i = 1; i <= 3; i++) add("sim_coin", 1'b1, 1'b0, 1'b0, idl(3'(i)));
    add("sim_buy_coin", 1'b1, 1'b1, 1'b0, cup(3'd1));
    for (int i = 0; i < 4; i++) add("sim_brew", 1'b0, 1'b0, 1'b0, brw(3'd1));
    add("sim_done", 1'b0, 1'b0, 1'b0, don(3'd1));
    add("sim_ret", 1'b0, 1'b0, 1'b0, chg(3'd1));
    add("sim_idle", 1'b0, 1'b0, 1'b0, idl(3'd0));
    // cancel + buy together at credit 4.
    for (int i = 1; i <= 4; i++) add("cb_coin", 1'b1, 1'b0, 1'b0, idl(3'(i)));
    add("cb_cancel_buy", 1'b0, 1'b1, 1'b1, chg(3'd4));
    for (int i = 3; i >= 1; i--) add("cb_ret", 1'b0, 1'b0, 1'b0, chg(3'(i)));
    add("cb_idle", 1'b0, 1'b0, 1'b0, idl(3'd0));

    // Power-on reset.
    rst_n = 1'b0;
    bus.coin = 1'b0; bus.buy = 1'b0; bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", observed(), idl(3'd0));
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].coin, vecs[i].buy,
            vecs[i].cancel, vecs[i].exp);
    end

    // Asynchronous reset in the middle of BREW with credit 2.
    for (int i = 1; i <= 5; i++) apply("rst_coin", 1'b1, 1'b0, 1'b0, idl(3'(i)));
    apply("rst_buy", 1'b0, 1'b1, 1'b0, cup(3'd2));
    apply("rst_brew1", 1'b0, 1'b0, 1'b0, brw(3'd2));
    apply("rst_brew2", 1'b0, 1'b0, 1'b0, brw(3'd2));
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), idl(3'd0));
    @(negedge clk);
    check("reset_hold", observed(), idl(3'd0));
    rst_n = 1'b1;
    apply("post_rst_idle", 1'b0, 1'b0, 1'b0, idl(3'd0));
    apply("post_rst_coin", 1'b1, 1'b0, 1'b0, idl(3'd1));
    apply("post_rst_buy_low", 1'b0, 1'b1, 1'b0, idl(3'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
